instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// Instruction fetch stage directly upstream of the main control decoder: owns the PC,
// fetches 32-bit words from instruction memory over a req/ack handshake, holds the fetched
// instruction stable (op field = instr[31:26] drives the decoder) until the consumer retires
// it, then advances PC by 4 or to the beq target.
// PARAMETERS
// RESET_PC    32'h0000_0000  PC value loaded on reset
// TIMEOUT     16             max cycles imem_req may stay high without imem_ack before error
// CNT_W       32             width of retired-instruction counter
// PORTS
// clk           in   1      rising-edge clock; only clock
// reset         in   1      synchronous, active-high reset
// imem_req      out  1      fetch request to instruction memory
// imem_addr     out  32     word-aligned fetch address (== pc)
// imem_ack      in   1      memory has returned data on imem_rdata this cycle
// imem_rdata    in   32     instruction word, valid when imem_ack=1
// instr         out  32     held instruction register
// op            out  6      instr[31:26], feeds main control decoder
// instr_valid   out  1      instr/op are valid and stable
// instr_ready   in   1      consumer retires current instruction this cycle
// branch_take   in   1      Branch & Zero for the current instr; sampled only on retire
// pc            out  32     address of current/pending instruction
// pc_plus4      out  32     pc + 4
// retired_cnt   out  CNT_W  count of retired instructions, wraps modulo 2^CNT_W
// fetch_err     out  1      sticky: memory timeout occurred
// BEHAVIOUR
// - Reset (sync, active-high): state=FETCH, pc=RESET_PC, instr=0, instr_valid=0,
//   imem_req=0 in reset cycle, retired_cnt=0, fetch_err=0, timeout counter=0.
// - FSM states FETCH, HOLD, ERR:
//   FETCH: imem_req=1, imem_addr=pc held stable until ack. On imem_ack: instr<=imem_rdata,
//     ->HOLD. Timeout counter increments each FETCH cycle without ack; reaching TIMEOUT -> ERR.
//   HOLD: instr_valid=1, imem_req=0, instr/op/pc stable. On instr_ready: ->FETCH,
//     retired_cnt+=1, pc <= branch_take ? pc+4+(sext(instr[15:0])<<2) : pc+4.
//   ERR: imem_req=0, instr_valid=0, fetch_err=1; exits only on reset.
// - Latency: ack in cycle N -> instr_valid=1 in N+1. Ready in HOLD cycle M -> imem_req=1 with
//   new pc in M+1. Zero-wait memory + always-ready consumer = 1 instruction per 2 cycles.
// - Arithmetic: all PC math modulo 2^32 (0xFFFF_FFFC+4 wraps to 0). Offset sign-extended
//   16->32 then shifted left 2 before add. pc bits [1:0] always 0.
// - imem_ack outside FETCH ignored. imem_ack in the same cycle counter hits TIMEOUT: ack wins.
// - instr_ready/branch_take ignored when instr_valid=0.
// - Reset mid-FETCH: request dropped; ack in the cycle after reset ignored unless the FSM is
//   already in FETCH with pc=RESET_PC (then it is accepted as the RESET_PC fetch).
// - Reset with reset high and instr_ready high same cycle: reset wins, no retire counted.
// TESTING
// 1. Reset, zero-wait mem, ready=1, branch_take=0, 4 instrs -> imem_addr 0,4,8,C; instr_valid
//    pulses every 2nd cycle; retired_cnt=4.
// 2. Fetch beq at pc=0x10 with imm=0xFFFE, branch_take=1 on retire -> next imem_addr=0x0C;
//    imm=0x0003 -> 0x20.
// 3. Ack delayed 5 cycles -> imem_req and imem_addr stable all 5 cycles; instr_valid 1 cycle
//    after ack; instr_ready held 0 for 3 cycles -> instr/op unchanged, no new req.
// 4. No ack for TIMEOUT=16 cycles -> fetch_err=1, imem_req=0 from cycle 17; reset clears.
// 5. pc=0xFFFF_FFFC retire no branch -> imem_addr=0; retired_cnt from 2^CNT_W-1 wraps to 0.
// 6. Reset asserted in HOLD with instr_ready=1 -> pc=RESET_PC, retired_cnt unchanged(0 after
//    reset), instr_valid=0 next cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake, holds the
// instruction until the decoder retires it, then advances to pc+4 or the beq target.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [5:0]       op,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             branch_take,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             fetch_err
);

    localparam int          TMO_W       = $clog2(TIMEOUT + 1);
    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        ERR   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic [31:0]        seq_pc;
    logic [31:0]        br_offset;

    assign seq_pc    = pc_q + 32'd4;
    // beq immediate: sign-extend 16->32, then word-scale (<<2); keeps pc[1:0] at zero
    assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        tmo_d     = tmo_q;

        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    tmo_d   = '0;
                    state_d = HOLD;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        state_d = ERR;
                    end
                end
            end

            HOLD: begin
                if (instr_ready) begin
                    retired_d = retired_q + 1'b1;
                    pc_d      = branch_take ? (seq_pc + br_offset) : seq_pc;
                    tmo_d     = '0;
                    state_d   = FETCH;
                end
            end

            ERR: begin
                state_d = ERR;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC_AL;
            instr_q   <= '0;
            retired_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            tmo_q     <= tmo_d;
        end
    end

    // Request is masked during the reset cycle so memory never sees a fetch from stale state.
    assign imem_req    = (state_q == FETCH) && !reset;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign instr_valid = (state_q == HOLD);
    assign pc          = pc_q;
    assign pc_plus4    = seq_pc;
    assign retired_cnt = retired_q;
    assign fetch_err   = (state_q == ERR);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, hand-written corner
// sequences, a counter/PC wrap instance, and randomized transactions against a PC model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_take;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired_cnt;
    logic        fetch_err;

    logic        w_reset;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_imem_ack;
    logic [31:0] w_imem_rdata;
    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic        w_instr_valid;
    logic        w_instr_ready;
    logic        w_branch_take;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [2:0]  w_retired_cnt;
    logic        w_fetch_err;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .op(op),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .branch_take(branch_take),
        .pc(pc), .pc_plus4(pc_plus4), .retired_cnt(retired_cnt), .fetch_err(fetch_err)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16), .CNT_W(3)) u_wrap (
        .clk(clk), .reset(w_reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata), .instr(w_instr), .op(w_op),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
        .branch_take(w_branch_take), .pc(w_pc), .pc_plus4(w_pc_plus4),
        .retired_cnt(w_retired_cnt), .fetch_err(w_fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        bt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic rst, input logic ack, input logic [31:0] rdata,
                                input logic rdy, input logic bt, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.bt = bt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic [31:0] d,
                         input logic rd, input logic b);
        reset       = r;
        imem_ack    = a;
        imem_rdata  = d;
        instr_ready = rd;
        branch_take = b;
    endtask

    localparam logic [31:0] I0 = 32'h8C01_0000;
    localparam logic [31:0] I1 = 32'h0000_0020;
    localparam logic [31:0] I2 = 32'hAC01_0004;
    localparam logic [31:0] I3 = 32'h2001_0001;
    localparam logic [31:0] B1 = 32'h1022_FFFE;
    localparam logic [31:0] B2 = 32'h1022_0003;
    localparam logic [31:0] W4 = 32'h3C01_1234;
    localparam logic [31:0] W5 = 32'h2402_0007;
    localparam logic [31:0] WD = 32'h8C22_0010;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
        logic [31:0] word;
        logic        bt;
        int          off;
        int          d;
        int          r;

        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        w_reset = 1'b1; w_imem_ack = 1'b0; w_imem_rdata = 32'h0;
        w_instr_ready = 1'b0; w_branch_take = 1'b0;

        vecs[0]  = mk(0, 1, I0,           0, 1, 1, 32'h00, 0, 32'h0, 0);
        vecs[1]  = mk(0, 0, 32'h0,        1, 0, 0, 32'h00, 1, I0,    0);
        vecs[2]  = mk(0, 1, I1,           0, 0, 1, 32'h04, 0, I0,    1);
        vecs[3]  = mk(0, 0, 32'h0,        1, 0, 0, 32'h04, 1, I1,    1);
        vecs[4]  = mk(0, 1, I2,           0, 0, 1, 32'h08, 0, I1,    2);
        vecs[5]  = mk(0, 0, 32'h0,        1, 0, 0, 32'h08, 1, I2,    2);
        vecs[6]  = mk(0, 1, I3,           0, 0, 1, 32'h0C, 0, I2,    3);
        vecs[7]  = mk(0, 0, 32'h0,        1, 0, 0, 32'h0C, 1, I3,    3);
        vecs[8]  = mk(0, 1, B1,           0, 0, 1, 32'h10, 0, I3,    4);
        vecs[9]  = mk(0, 0, 32'h0,        1, 1, 0, 32'h10, 1, B1,    4);
        vecs[10] = mk(0, 1, B2,           0, 0, 1, 32'h0C, 0, B1,    5);
        vecs[11] = mk(0, 0, 32'h0,        1, 0, 0, 32'h0C, 1, B2,    5);
        vecs[12] = mk(0, 1, B2,           0, 0, 1, 32'h10, 0, B2,    6);
        vecs[13] = mk(0, 0, 32'h0,        1, 1, 0, 32'h10, 1, B2,    6);
        vecs[14] = mk(0, 1, W4,           0, 0, 1, 32'h20, 0, B2,    7);
        vecs[15] = mk(1, 0, 32'h0,        1, 0, 0, 32'h20, 1, W4,    7);
        vecs[16] = mk(0, 1, W5,           1, 1, 1, 32'h00, 0, 32'h0, 0);
        vecs[17] = mk(0, 1, 32'hDEADBEEF, 0, 0, 0, 32'h00, 1, W5,    0);
        vecs[18] = mk(0, 0, 32'h0,        0, 0, 0, 32'h00, 1, W5,    0);

        // Reset state, sampled while reset is still high.
        @(negedge clk);
        #1;
        check("rst_req",   32'(imem_req),    32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_pc",    pc,               32'h0);
        check("rst_instr", instr,            32'h0);
        check("rst_cnt",   retired_cnt,      32'h0);
        check("rst_err",   32'(fetch_err),   32'h0);
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].bt);
            #1;
            check($sformatf("v%0d_req", i),   32'(imem_req),    32'(vecs[i].e_req));
            check($sformatf("v%0d_addr", i),  imem_addr,        vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_instr", i), instr,            vecs[i].e_instr);
            check($sformatf("v%0d_op", i),    32'(op),          32'(vecs[i].e_instr[31:26]));
            check($sformatf("v%0d_cnt", i),   retired_cnt,      vecs[i].e_cnt);
            check($sformatf("v%0d_err", i),   32'(fetch_err),   32'h0);
            @(negedge clk);
        end

        // Delayed ack: request and address stay put, then consumer stalls for 3 cycles.
        drive(0, 0, 32'h0, 1, 0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("dly%0d_req", i),  32'(imem_req), 32'h1);
            check($sformatf("dly%0d_addr", i), imem_addr,     32'h4);
            @(negedge clk);
        end
        drive(0, 1, WD, 0, 0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d_valid", i), 32'(instr_valid), 32'h1);
            check($sformatf("stall%0d_instr", i), instr,            WD);
            check($sformatf("stall%0d_op", i),    32'(op),          32'h23);
            check($sformatf("stall%0d_req", i),   32'(imem_req),    32'h0);
            @(negedge clk);
        end
        drive(0, 0, 32'h0, 1, 0);
        @(negedge clk);

        // Timeout: 16 unanswered FETCH cycles, then sticky error.
        drive(0, 0, 32'h0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            #1;
            check($sformatf("tmo%0d_req", i),  32'(imem_req),  32'h1);
            check($sformatf("tmo%0d_addr", i), imem_addr,      32'h8);
            check($sformatf("tmo%0d_err", i),  32'(fetch_err), 32'h0);
            @(negedge clk);
        end
        #1;
        check("err_flag",  32'(fetch_err),   32'h1);
        check("err_req",   32'(imem_req),    32'h0);
        check("err_valid", 32'(instr_valid), 32'h0);
        check("err_cnt",   retired_cnt,      32'h2);
        drive(0, 1, WD, 1, 0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0);
        #1;
        check("err_sticky", 32'(fetch_err),   32'h1);
        check("err_noack",  32'(instr_valid), 32'h0);
        drive(1, 0, 32'h0, 0, 0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0);
        #1;
        check("clr_err",  32'(fetch_err), 32'h0);
        check("clr_req",  32'(imem_req),  32'h1);
        check("clr_addr", imem_addr,      32'h0);
        check("clr_cnt",  retired_cnt,    32'h0);

        // Ack arriving in the 16th waiting cycle beats the timeout.
        for (int i = 1; i <= 15; i++) @(negedge clk);
        drive(0, 1, I3, 0, 0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0);
        #1;
        check("race_valid", 32'(instr_valid), 32'h1);
        check("race_err",   32'(fetch_err),   32'h0);
        check("race_instr", instr,            I3);

        // PC wrap at 0xFFFF_FFFC and 3-bit retired counter wrap.
        @(negedge clk);
        w_reset = 1'b0; w_imem_ack = 1'b1; w_imem_rdata = 32'h0000_0001;
        #1;
        check("wrap_req0",  32'(w_imem_req), 32'h1);
        check("wrap_addr0", w_imem_addr,     32'hFFFF_FFFC);
        @(negedge clk);
        w_imem_ack = 1'b0; w_instr_ready = 1'b1;
        #1;
        check("wrap_valid", 32'(w_instr_valid), 32'h1);
        check("wrap_pcp4",  w_pc_plus4,         32'h0);
        check("wrap_op",    32'(w_op),          32'h0);
        check("wrap_instr", w_instr,            32'h1);
        @(negedge clk);
        w_instr_ready = 1'b0;
        #1;
        check("wrap_addr1", w_imem_addr,          32'h0);
        check("wrap_cnt1",  32'(w_retired_cnt),   32'h1);
        check("wrap_pc1",   w_pc,                 32'h0);
        for (int k = 2; k <= 8; k++) begin
            w_imem_ack = 1'b1;
            @(negedge clk);
            w_imem_ack = 1'b0; w_instr_ready = 1'b1;
            @(negedge clk);
            w_instr_ready = 1'b0;
            #1;
            check($sformatf("wrap_cnt%0d", k), 32'(w_retired_cnt), 32'(k % 8));
        end
        check("wrap_err", 32'(w_fetch_err), 32'h0);

        // Randomized transactions against a PC/count model.
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 0);
        @(negedge clk);
        exp_pc  = 32'h0;
        exp_cnt = 32'h0;
        for (int t = 0; t < 150; t++) begin
            drive(0, 0, 32'h0, 0, 0);
            #1;
            check($sformatf("rnd%0d_req", t),  32'(imem_req), 32'h1);
            check($sformatf("rnd%0d_addr", t), imem_addr,     exp_pc);
            d = $urandom_range(0, 10);
            repeat (d) @(negedge clk);
            word = $urandom;
            drive(0, 1, word, 0, 0);
            @(negedge clk);
            drive(0, 0, 32'h0, 0, 0);
            #1;
            check($sformatf("rnd%0d_valid", t), 32'(instr_valid), 32'h1);
            check($sformatf("rnd%0d_instr", t), instr,            word);
            check($sformatf("rnd%0d_op", t),    32'(op),          32'(word >> 26));
            check($sformatf("rnd%0d_pc", t),    pc,               exp_pc);
            check($sformatf("rnd%0d_pcp4", t),  pc_plus4,         exp_pc + 32'd4);
            r = $urandom_range(0, 3);
            repeat (r) @(negedge clk);
            #1;
            check($sformatf("rnd%0d_hold", t), instr, word);
            bt = 1'($urandom_range(0, 1));
            drive(0, 0, 32'h0, 1, bt);
            @(negedge clk);
            off     = $signed(word[15:0]);
            exp_pc  = bt ? exp_pc + 4 + off * 4 : exp_pc + 4;
            exp_cnt = exp_cnt + 1;
            drive(0, 0, 32'h0, 0, 0);
            #1;
            check($sformatf("rnd%0d_cnt", t), retired_cnt, exp_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
